// File: rtl/ibus_axi_refill_bridge.sv
// Instruction-cache refill bridge: turns a single cmd/rsp line request into one
// AXI4 INCR read burst, returning beats in order and flagging response/RLAST errors.
module ibus_axi_refill_bridge #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned AXI_ID     = 0,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_pc,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_error,
    output logic                  M_AXI_ARID,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]            M_AXI_ARLEN,
    output logic [2:0]            M_AXI_ARSIZE,
    output logic [1:0]            M_AXI_ARBURST,
    output logic [2:0]            M_AXI_ARPROT,
    output logic [3:0]            M_AXI_ARCACHE,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RLAST,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY,
    output logic                  err_sticky,
    input  logic                  err_clear,
    output logic [CNT_WIDTH-1:0]  refill_count,
    output logic                  busy
);

    localparam int unsigned OFS_BITS = $clog2(LINE_WORDS * DATA_WIDTH / 8);
    localparam int unsigned BEAT_W   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFS_BITS;
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_cmd_ready;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_busy;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [BEAT_W-1:0]     r_beat;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_error;
    logic                  r_err_sticky;
    logic [CNT_WIDTH-1:0]  r_refill_count;

    logic w_cmd_fire;
    logic w_ar_fire;
    logic w_r_fire;
    logic w_final;
    logic w_resp_err;
    logic w_set_err;
    logic w_count_inc;

    assign w_cmd_fire  = cmd_valid & r_cmd_ready;
    assign w_ar_fire   = r_arvalid & M_AXI_ARREADY;
    assign w_r_fire    = M_AXI_RVALID & r_rready;
    assign w_final     = (r_beat == LAST_BEAT);
    assign w_resp_err  = (M_AXI_RRESP == 2'b10) | (M_AXI_RRESP == 2'b11);
    // An RLAST that disagrees with our own beat count is a protocol error either way.
    assign w_set_err   = w_r_fire & (w_resp_err | (M_AXI_RLAST != w_final));
    assign w_count_inc = w_r_fire & w_final & M_AXI_RLAST;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_cmd_fire) w_state_nxt = S_ADDR;
            S_ADDR: if (w_ar_fire) w_state_nxt = S_DATA;
            S_DATA: if (w_r_fire & (w_final | M_AXI_RLAST)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next state.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state        <= S_IDLE;
            r_cmd_ready    <= 1'b0;
            r_arvalid      <= 1'b0;
            r_rready       <= 1'b0;
            r_busy         <= 1'b0;
            r_araddr       <= '0;
            r_beat         <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_error    <= 1'b0;
            r_err_sticky   <= 1'b0;
            r_refill_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_arvalid   <= (w_state_nxt == S_ADDR);
            r_rready    <= (w_state_nxt == S_DATA);
            r_busy      <= (w_state_nxt != S_IDLE);
            if (w_cmd_fire)
                r_araddr <= cmd_pc & LINE_MASK;
            if (r_state != S_DATA)
                r_beat <= '0;
            else if (w_r_fire)
                r_beat <= r_beat + BEAT_W'(1);
            r_rsp_valid <= w_r_fire;
            r_rsp_error <= w_r_fire & w_resp_err;
            if (w_r_fire)
                r_rsp_data <= M_AXI_RDATA;
            if (w_set_err)
                r_err_sticky <= 1'b1;
            else if (err_clear)
                r_err_sticky <= 1'b0;
            if (w_count_inc)
                r_refill_count <= r_refill_count + CNT_WIDTH'(1);
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign rsp_error     = r_rsp_error;
    assign M_AXI_ARID    = 1'(AXI_ID);
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARLEN   = 8'(LINE_WORDS - 1);
    assign M_AXI_ARSIZE  = 3'($clog2(DATA_WIDTH / 8));
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARPROT  = 3'b100;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;
    assign err_sticky    = r_err_sticky;
    assign refill_count  = r_refill_count;
    assign busy          = r_busy;

endmodule

// File: tb/tb_ibus_axi_refill_bridge.sv
// Randomised bench for ibus_axi_refill_bridge: acts as the core and the AXI slave,
// predicting every response from a per-refill reference model.
module tb_ibus_axi_refill_bridge;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 8;
    localparam int unsigned CW = 16;

    logic          ACLK = 1'b0;
    logic          ARESETN;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_pc = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_error;
    logic          M_AXI_ARID;
    logic [AW-1:0] M_AXI_ARADDR;
    logic [7:0]    M_AXI_ARLEN;
    logic [2:0]    M_AXI_ARSIZE;
    logic [1:0]    M_AXI_ARBURST;
    logic [2:0]    M_AXI_ARPROT;
    logic [3:0]    M_AXI_ARCACHE;
    logic          M_AXI_ARVALID;
    logic          M_AXI_ARREADY = 1'b0;
    logic [DW-1:0] M_AXI_RDATA = '0;
    logic [1:0]    M_AXI_RRESP = 2'b00;
    logic          M_AXI_RLAST = 1'b0;
    logic          M_AXI_RVALID = 1'b0;
    logic          M_AXI_RREADY;
    logic          err_sticky;
    logic          err_clear = 1'b0;
    logic [CW-1:0] refill_count;
    logic          busy;

    always #5 ACLK = ~ACLK;

    ibus_axi_refill_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW), .AXI_ID(0), .CNT_WIDTH(CW)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pc(cmd_pc),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .err_sticky(err_sticky), .err_clear(err_clear),
        .refill_count(refill_count), .busy(busy)
    );

    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic          exp_sticky = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_error"}, rsp_error, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_arvalid"}, M_AXI_ARVALID, 0);
        chk({tag, "_araddr"}, M_AXI_ARADDR, 0);
        chk({tag, "_rready"}, M_AXI_RREADY, 0);
        chk({tag, "_sticky"}, err_sticky, 0);
        chk({tag, "_count"}, refill_count, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // mode 0: correct RLAST; 1: RLAST early at beat early_at; 2: RLAST missing on final beat.
    // abort_after >= 0 stops after that many beats, leaving the burst open for a reset.
    task automatic refill(input logic [AW-1:0] pc, input int dly, input int gap, input int err_beat,
                          input int mode, input int early_at, input bit second_cmd,
                          input bit fixed_data, input bit rnd_clr, input int abort_after);
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] d;
        logic          e, last, clr, is_err;
        int            nb;
        int            t;
        exp_addr = pc & ~AW'(LW * DW / 8 - 1);
        t = 0;
        while (cmd_ready !== 1'b1 && t < 20) begin
            @(negedge ACLK);
            t++;
        end
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_busy", busy, 0);
        cmd_valid = 1'b1;
        cmd_pc    = pc;
        @(negedge ACLK);
        cmd_valid = 1'b0;
        cmd_pc    = $urandom;
        chk("ar_valid", M_AXI_ARVALID, 1);
        chk("ar_addr", M_AXI_ARADDR, exp_addr);
        chk("ar_busy", busy, 1);
        chk("ar_cmd_ready", cmd_ready, 0);
        for (int i = 0; i < dly; i++) begin
            if (second_cmd) begin
                cmd_valid = 1'b1;
                cmd_pc    = $urandom;
            end
            @(negedge ACLK);
            chk("ar_hold_valid", M_AXI_ARVALID, 1);
            chk("ar_hold_addr", M_AXI_ARADDR, exp_addr);
            chk("ar_hold_cmd_ready", cmd_ready, 0);
        end
        cmd_valid     = 1'b0;
        M_AXI_ARREADY = 1'b1;
        @(negedge ACLK);
        M_AXI_ARREADY = 1'b0;
        chk("ar_done_valid", M_AXI_ARVALID, 0);
        chk("data_rready", M_AXI_RREADY, 1);
        nb = (mode == 1) ? early_at + 1 : LW;
        if (abort_after >= 0) nb = abort_after;
        for (int i = 0; i < nb; i++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge ACLK);
                chk("gap_rsp_valid", rsp_valid, 0);
            end
            d    = fixed_data ? DW'(32'hA0 + i) : DW'($urandom);
            e    = (i == err_beat);
            last = (mode == 0) ? (i == LW - 1) : (mode == 1) ? (i == early_at) : 1'b0;
            clr  = rnd_clr && ($urandom_range(3) == 0);
            M_AXI_RVALID = 1'b1;
            M_AXI_RDATA  = d;
            M_AXI_RRESP  = {e, 1'($urandom_range(1))};
            M_AXI_RLAST  = last;
            err_clear    = clr;
            @(negedge ACLK);
            M_AXI_RVALID = 1'b0;
            M_AXI_RLAST  = 1'b0;
            err_clear    = 1'b0;
            is_err = e || (mode != 0 && i == LW - 1) || (mode == 1 && i == early_at);
            if (is_err) exp_sticky = 1'b1;
            else if (clr) exp_sticky = 1'b0;
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_data", rsp_data, d);
            chk("rsp_error", rsp_error, e);
            chk("err_sticky", err_sticky, exp_sticky);
            if (i < nb - 1 || abort_after >= 0) chk("mid_rready", M_AXI_RREADY, 1);
        end
        if (abort_after < 0) begin
            if (mode == 0) exp_cnt = exp_cnt + CW'(1);
            chk("end_busy", busy, 0);
            chk("end_cmd_ready", cmd_ready, 1);
            chk("end_rready", M_AXI_RREADY, 0);
            chk("end_count", refill_count, exp_cnt);
            @(negedge ACLK);
            chk("end_rsp_valid", rsp_valid, 0);
            chk("end_arvalid", M_AXI_ARVALID, 0);
        end
    endtask

    task automatic clear_pulse();
        err_clear = 1'b1;
        @(negedge ACLK);
        err_clear  = 1'b0;
        exp_sticky = 1'b0;
        chk("clear_sticky", err_sticky, 0);
    endtask

    initial begin
        ARESETN = 1'b1;
        #1 ARESETN = 1'b0;
        #1 check_reset_outputs("por");
        repeat (3) @(negedge ACLK);
        check_reset_outputs("por_hold");
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("por_release_cmd_ready", cmd_ready, 1);
        chk("arlen", M_AXI_ARLEN, LW - 1);
        chk("arsize", M_AXI_ARSIZE, 2);
        chk("arburst", M_AXI_ARBURST, 1);
        chk("arprot", M_AXI_ARPROT, 4);
        chk("arcache", M_AXI_ARCACHE, 3);
        chk("arid", M_AXI_ARID, 0);

        refill(32'h0000_1234, 0, 0, -1, 0, 0, 1'b0, 1'b1, 1'b0, -1);
        chk("first_addr_literal", M_AXI_ARADDR, 32'h0000_1220);
        refill(32'h0000_2468, 5, 0, -1, 0, 0, 1'b1, 1'b0, 1'b0, -1);
        refill(32'h8000_0040, 1, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0, -1);
        chk("err3_sticky", err_sticky, 1);
        clear_pulse();
        refill(32'h0000_3000, 0, 0, -1, 1, 5, 1'b0, 1'b0, 1'b0, -1);
        chk("early_sticky", err_sticky, 1);
        clear_pulse();
        refill(32'h0000_3100, 0, 0, -1, 2, 0, 1'b0, 1'b0, 1'b0, -1);
        chk("nolast_sticky", err_sticky, 1);
        clear_pulse();
        refill(32'h0000_4004, 0, 2, -1, 0, 0, 1'b0, 1'b0, 1'b0, -1);
        refill(32'h0000_4044, 0, 2, -1, 0, 0, 1'b0, 1'b0, 1'b0, -1);

        refill(32'h0000_5000, 0, 0, -1, 0, 0, 1'b0, 1'b0, 1'b0, 4);
        #2 ARESETN = 1'b0;
        #1 check_reset_outputs("mid_rst");
        exp_cnt    = '0;
        exp_sticky = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            M_AXI_RVALID = 1'b1;
            M_AXI_RDATA  = $urandom;
            @(negedge ACLK);
            chk("stale_rready", M_AXI_RREADY, 0);
            chk("stale_rsp_valid", rsp_valid, 0);
        end
        M_AXI_RVALID = 1'b0;
        refill(32'h0000_0100, 0, 0, -1, 0, 0, 1'b0, 1'b0, 1'b0, -1);

        for (int n = 0; n < 20; n++) begin
            int mode;
            mode = ($urandom_range(4) == 0) ? int'($urandom_range(2, 1)) : 0;
            refill($urandom, $urandom_range(4), $urandom_range(2),
                   ($urandom_range(1) == 1) ? int'($urandom_range(LW - 1)) : -1,
                   mode, $urandom_range(LW - 2), 1'($urandom_range(1)), 1'b0, 1'b1, -1);
            if ($urandom_range(2) == 0) clear_pulse();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ibus_axi_refill_bridge.md
Name: ibus_axi_refill_bridge

Overview:
Converts the VexRiscv cached instruction-bus refill interface (cmd/rsp) into AXI4 INCR read bursts on the M_INST_AXI master port. It sits directly downstream of the core's instruction cache and upstream of the M_INST_AXI interconnect/slave. It supports one outstanding line refill, returns beats to the core in order, and flags AXI error responses and RLAST protocol violations.

Parameters:
ADDR_WIDTH, 32, AXI/core address width
DATA_WIDTH, 32, AXI/core data width (bytes per beat = DATA_WIDTH/8)
LINE_WORDS, 8, beats per cache-line refill (power of two, 1..256)
AXI_ID, 0, constant ARID value
CNT_WIDTH, 16, width of refill_count

Ports:
ACLK  in  1  clock, all logic rising-edge
ARESETN  in  1  asynchronous active-low reset
cmd_valid  in  1  core requests line refill
cmd_ready  out  1  bridge accepts command
cmd_pc  in  ADDR_WIDTH  any address within requested line
rsp_valid  out  1  one refill beat valid (no backpressure)
rsp_data  out  DATA_WIDTH  beat data
rsp_error  out  1  beat carried SLVERR/DECERR
M_AXI_ARID  out  1  =AXI_ID
M_AXI_ARADDR  out  ADDR_WIDTH  line-aligned address
M_AXI_ARLEN  out  8  =LINE_WORDS-1
M_AXI_ARSIZE  out  3  =clog2(DATA_WIDTH/8)
M_AXI_ARBURST  out  2  =2'b01 INCR
M_AXI_ARPROT  out  3  =3'b100 (instruction)
M_AXI_ARCACHE  out  4  =4'b0011
M_AXI_ARVALID  out  1  address valid
M_AXI_ARREADY  in  1  address accepted
M_AXI_RDATA  in  DATA_WIDTH  read data
M_AXI_RRESP  in  2  read response
M_AXI_RLAST  in  1  last beat
M_AXI_RVALID  in  1  read data valid
M_AXI_RREADY  out  1  read data accept
err_sticky  out  1  sticky error (RRESP!=OKAY or RLAST mismatch)
err_clear  in  1  clears err_sticky (single-cycle pulse)
refill_count  out  CNT_WIDTH  completed refills, wraps to 0
busy  out  1  refill in progress

Behaviour:
- Reset (ARESETN=0, asynchronous): state IDLE; cmd_ready, rsp_valid, rsp_error, M_AXI_ARVALID, M_AXI_RREADY, err_sticky, busy = 0; refill_count=0; ARADDR, rsp_data = 0. Reset mid-burst abandons the burst; stale R beats after release are not consumed (RREADY=0 in IDLE).
- FSM IDLE -> ADDR -> DATA -> IDLE.
- IDLE: cmd_ready=1. cmd_valid&cmd_ready: latch ARADDR = cmd_pc with low clog2(LINE_WORDS*DATA_WIDTH/8) bits cleared; next cycle ARVALID=1, busy=1, state ADDR.
- ADDR: hold ARVALID/ARADDR stable until ARREADY; on handshake ARVALID=0 next cycle, beat counter=0, state DATA. cmd_ready=0 outside IDLE.
- DATA: RREADY=1. Each RVALID&RREADY: registered rsp_valid=1 next cycle with rsp_data=RDATA, rsp_error=(RRESP[1]==1); latency 1 cycle, beats in order, no gaps added. Counter increments.
- Burst end: beat LINE_WORDS-1 accepted -> IDLE, refill_count+1 (wraps), busy=0 next cycle; cmd_ready=1 that same next cycle.
- RLAST mismatch: RLAST=1 before final beat -> err_sticky=1, treat as end of burst (return to IDLE, no count increment). RLAST=0 on final beat -> err_sticky=1, still return to IDLE.
- err_sticky set by any error beat; err_clear clears; simultaneous set and clear -> set wins.
- refill_count increments even if error beats occurred (RLAST-correct burst).
- Beats received while ARVALID still high (slave answers before ARREADY) are not possible under AXI; no handling required.

Test Plan:
- Reset, cmd_pc=0x0000_1234, slave returns 8 OKAY beats 0xA0..0xA7 -> ARADDR=0x0000_1220, ARLEN=7, ARSIZE=2, ARBURST=1, ARPROT=4; rsp_data 0xA0..0xA7 one cycle after each R handshake; refill_count=1.
- ARREADY delayed 5 cycles -> ARVALID/ARADDR stable all 5 cycles; cmd_ready=0 and second cmd_valid ignored until burst done.
- Beat 3 RRESP=2'b10 -> rsp_error=1 only on beat 3; err_sticky=1; refill_count increments; err_clear pulse -> err_sticky=0.
- RLAST asserted on beat 5 -> err_sticky=1, FSM IDLE, cmd_ready=1, refill_count unchanged.
- RVALID gaps (1 beat every 3 cycles) -> rsp_valid pulses match, data order preserved; back-to-back two refills reach refill_count=2.
- ARESETN low mid-DATA (after beat 4) -> all outputs 0 immediately; after release new cmd_pc=0x100 issues fresh burst at 0x100.
